multdiv_seq: RTL and testbench
==============================

# multdiv_seq

Parametrised iterative multiply/divide unit that replaces the fixed 32-bit multdiv in the processor's execute stage. It accepts one request at a time and computes one quotient or product bit per clock. It supports signed and unsigned modes and returns both halves of the result: the high product word, or the remainder. It adds an explicit busy/ready handshake, asynchronous reset, and well-defined results for every exception case.

## Interface
- WIDTH, 32: operand and result width in bits; legal values are 8 to 64.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter. Derived; do not override.

- clock  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- data_operandA  in  WIDTH  multiplicand or dividend
- data_operandB  in  WIDTH  multiplier or divisor
- ctrl_MULT  in  1  multiply request, one-cycle pulse or level
- ctrl_DIV  in  1  divide request
- ctrl_SIGNED  in  1  1 = two's-complement operands, 0 = unsigned
- data_result  out  WIDTH  low product word or quotient
- data_result_hi  out  WIDTH  high product word or remainder
- data_exception  out  1  exception flag, valid while results are held
- data_resultRDY  out  1  one-cycle pulse when results become valid
- busy  out  1  high while a request is in progress

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset puts the FSM in IDLE and drives every output and internal register to 0.
- **Accepting a request:** a request is accepted on a rising edge when the FSM is in IDLE or DONE and ctrl_MULT or ctrl_DIV is 1.
  - If both are 1, the multiply wins.
  - Operands, op and ctrl_SIGNED are captured at the accepting edge.
  - In signed mode, negative operands are converted to magnitudes. The result sign is recorded as A[W-1]^B[W-1] for MULT and as A[W-1] for the remainder.
- **Requests while busy:** ctrl_MULT and ctrl_DIV are ignored in CALC and FIX. The operation in flight is never restarted or aborted by a request.
- **CALC:** runs exactly WIDTH iterations, with the counter counting 0..WIDTH-1.
  - MULT uses unsigned radix-2 shift-add on a 2*WIDTH accumulator.
  - DIV uses unsigned restoring shift-subtract. Each iteration shifts the remainder/quotient pair left, attempts a subtract, and keeps the subtract and sets the quotient bit 1 when the result is non-negative.
- **FIX (one cycle):**
  - Negate the product, quotient or remainder as the recorded signs require.
  - Register data_result and data_result_hi.
  - Evaluate the exception.
- **DONE (one cycle):** data_resultRDY=1. The FSM goes to IDLE, or to CALC if a new request is accepted on this edge.
- **Result holding:** data_result, data_result_hi and data_exception hold their values until the FIX of the next operation. They do not return to 0 after the RDY pulse.
- **Exceptions and special results:**
  - MULT overflow: unsigned, the high word is non-zero; signed, the high word is not the sign extension of bit WIDTH-1 of the low word. The full 2*WIDTH product is still returned.
  - Divide by zero: quotient = all-ones, remainder = dividend (original, signed value), exception=1.
  - Signed MIN / -1: quotient = MIN, remainder = 0, exception=1.
  - All other cases: exception=0.
- busy=1 in CALC and FIX, and in DONE only if a new request is accepted.

## Timing
- Name the accepting edge E0.
  - CALC iterations occur at E1..E_WIDTH.
  - The FIX registers are updated at E_WIDTH+1.
  - data_resultRDY is high from E_WIDTH+1 to E_WIDTH+2.
- Latency from the accepting edge to RDY is WIDTH+1 cycles, e.g. 33 for WIDTH=32.
- Back-to-back throughput: one operation per WIDTH+2 cycles. This is achieved by issuing the next request during DONE.
- busy rises combinationally-free, i.e. from the register set at E0. It falls at E_WIDTH+2 unless a new request is accepted.
- **Reset mid-operation:** clrn low forces IDLE and clears all outputs within the same cycle, because the reset is asynchronous. The operation is lost and no RDY pulse occurs. On reset release the unit accepts a request at the first rising edge.

## Configuration
- `MULTDIV_DIV0_FAST_EN`
  - **Defined:** a divide whose captured divisor is 0 skips CALC. E0 goes to FIX and E1 goes to DONE, so RDY is high from E1 to E2 (latency 1). Results are as specified for divide by zero.
  - **Undefined:** divide by zero runs the full WIDTH iterations with the normal latency. The same results are forced in FIX.
  - Multiply latency is unaffected either way.

## Test plan
- **Reset:** hold clrn=0, then release. All outputs are 0 and busy=0. Assert clrn=0 at iteration 10 of a MULT: outputs clear immediately and no RDY pulse follows.
- **Unsigned MULT** (WIDTH=32): 0xFFFFFFFF * 0x2. RDY pulses exactly 33 cycles after the accepting edge, with result=0xFFFFFFFE, result_hi=0x1, exception=1.
- **Signed MULT:** -7 * 6. result=0xFFFFFFD6, result_hi=0xFFFFFFFF, exception=0. Issue the next request during DONE: it is accepted, and its RDY comes 34 cycles after the previous RDY.
- **Signed DIV:** -7 / 2 gives quotient 0xFFFFFFFD and remainder 0xFFFFFFFF. 0x80000000 / -1 gives quotient 0x80000000, remainder 0, exception=1.
- **Divide by zero:** 5 / 0 gives quotient 0xFFFFFFFF, remainder 5, exception=1. RDY latency is 1 cycle with `MULTDIV_DIV0_FAST_EN` defined and 33 cycles without it.
- **Request rules:** pulse ctrl_DIV at iteration 5 of a MULT: it is ignored and the MULT result is correct. Assert ctrl_MULT and ctrl_DIV together in IDLE: a multiply is performed.

Source files
------------

// File: rtl/multdiv_seq.sv
// Iterative radix-2 multiply / restoring divide unit, one result bit per clock, signed or unsigned.
// Optional macro MULTDIV_DIV0_FAST_EN: a divide by zero skips the iteration phase.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             clrn,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = neg_w(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;
    logic               op_div_q, op_div_d;
    logic               signed_q, signed_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               b_zero_q, b_zero_d;
    logic               min_neg1_q, min_neg1_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic               accept_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     mult_sum_s;
    logic [WIDTH:0]     div_top_s;
    logic [WIDTH-1:0]   div_sub_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   fix_lo_s, fix_hi_s;
    logic               fix_exc_s;

    assign accept_s   = ((state_q == IDLE) || (state_q == DONE)) && (ctrl_MULT || ctrl_DIV);
    assign a_mag_s    = magnitude(data_operandA, ctrl_SIGNED);
    assign b_mag_s    = magnitude(data_operandB, ctrl_SIGNED);
    assign mult_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    // Shifted partial remainder needs one extra bit before the trial subtract.
    assign div_top_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge_s   = (div_top_s >= {1'b0, mcand_q});
    assign div_sub_s  = div_top_s[WIDTH-1:0] - mcand_q;

    // Sign correction and exception evaluation applied in FIX.
    always_comb begin
        prod_s    = neg_res_q ? neg_2w(acc_q) : acc_q;
        quo_s     = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_s     = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        fix_lo_s  = ZERO_W;
        fix_hi_s  = ZERO_W;
        fix_exc_s = 1'b0;
        if (op_div_q) begin
            if (b_zero_q) begin
                fix_lo_s  = ONES_W;
                fix_hi_s  = a_orig_q;
                fix_exc_s = 1'b1;
            end else if (min_neg1_q) begin
                fix_lo_s  = MIN_W;
                fix_hi_s  = ZERO_W;
                fix_exc_s = 1'b1;
            end else begin
                fix_lo_s  = quo_s;
                fix_hi_s  = rem_s;
                fix_exc_s = 1'b0;
            end
        end else begin
            fix_lo_s = prod_s[WIDTH-1:0];
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            if (signed_q) begin
                fix_exc_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
            end else begin
                fix_exc_s = (prod_s[2*WIDTH-1:WIDTH] != ZERO_W);
            end
        end
    end

    // Next-state, datapath iteration and output register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        a_orig_d    = a_orig_q;
        op_div_d    = op_div_q;
        signed_d    = signed_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        b_zero_d    = b_zero_q;
        min_neg1_d  = min_neg1_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        exc_d       = exc_q;
        rdy_d       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    op_div_d   = ~ctrl_MULT;
                    signed_d   = ctrl_SIGNED;
                    a_orig_d   = data_operandA;
                    neg_res_d  = ctrl_SIGNED & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
                    neg_rem_d  = ctrl_SIGNED & data_operandA[WIDTH-1];
                    b_zero_d   = (data_operandB == ZERO_W);
                    min_neg1_d = ctrl_SIGNED && (data_operandA == MIN_W) && (data_operandB == ONES_W);
                    cnt_d      = {CNT_W{1'b0}};
                    if (ctrl_MULT) begin
                        mcand_d = a_mag_s;
                        acc_d   = {ZERO_W, b_mag_s};
                    end else begin
                        mcand_d = b_mag_s;
                        acc_d   = {ZERO_W, a_mag_s};
                    end
`ifdef MULTDIV_DIV0_FAST_EN
                    if (!ctrl_MULT && (data_operandB == ZERO_W)) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (op_div_q) begin
                    acc_d = {(div_ge_s ? div_sub_s : div_top_s[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ge_s};
                end else if (acc_q[0]) begin
                    acc_d = {mult_sum_s, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                result_d    = fix_lo_s;
                result_hi_d = fix_hi_s;
                exc_d       = fix_exc_s;
                rdy_d       = 1'b1;
                state_d     = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            mcand_q     <= ZERO_W;
            a_orig_q    <= ZERO_W;
            op_div_q    <= 1'b0;
            signed_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            b_zero_q    <= 1'b0;
            min_neg1_q  <= 1'b0;
            result_q    <= ZERO_W;
            result_hi_q <= ZERO_W;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            a_orig_q    <= a_orig_d;
            op_div_q    <= op_div_d;
            signed_q    <= signed_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            b_zero_q    <= b_zero_d;
            min_neg1_q  <= min_neg1_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            exc_q       <= exc_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_result_hi = result_hi_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq (WIDTH=32): directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_multdiv_seq;
    localparam int W = 32;

    logic          clock;
    logic          clrn;
    logic [W-1:0]  data_operandA, data_operandB;
    logic          ctrl_MULT, ctrl_DIV, ctrl_SIGNED;
    logic [W-1:0]  data_result, data_result_hi;
    logic          data_exception, data_resultRDY, busy;

    multdiv_seq #(.WIDTH(W)) dut (
        .clock(clock), .clrn(clrn),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .ctrl_SIGNED(ctrl_SIGNED),
        .data_result(data_result), .data_result_hi(data_result_hi),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         exc;
        int           acc_cyc;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rdy_cnt = 0;
    int   last_rdy_cyc = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural values.
    function automatic exp_t model(input bit mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit sgn);
        exp_t e;
        longint sa, sb, sp, q, r;
        logic [63:0] p;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        e.lat = W + 1;
        e.acc_cyc = 0;
        if (mul) begin
            if (sgn) begin
                sp    = sa * sb;
                p     = sp;
                e.exc = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
            end else begin
                p     = {32'd0, a} * {32'd0, b};
                e.exc = (p > 64'h0000_0000_FFFF_FFFF);
            end
            e.lo = p[31:0];
            e.hi = p[63:32];
        end else if (b == 32'd0) begin
            e.lo  = 32'hFFFF_FFFF;
            e.hi  = a;
            e.exc = 1'b1;
`ifdef MULTDIV_DIV0_FAST_EN
            e.lat = 1;
`endif
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo  = 32'h8000_0000;
            e.hi  = 32'd0;
            e.exc = 1'b1;
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            e.lo  = q[31:0];
            e.hi  = r[31:0];
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every RDY pulse pops one expectation and compares it.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (data_resultRDY === 1'b1) begin
            rdy_cnt++;
            last_rdy_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("result_lo", {32'd0, data_result}, {32'd0, e.lo});
                chk("result_hi", {32'd0, data_result_hi}, {32'd0, e.hi});
                chk("exception", {63'd0, data_exception}, {63'd0, e.exc});
                chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    // Called at a falling edge; the request is seen by the next rising edge.
    task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sgn, input bit push);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        ctrl_SIGNED   = sgn;
        if (push) begin
            e = model(m, a, b, sgn);
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_rdy(input string name);
        int start;
        int n;
        start = rdy_cnt;
        n = 0;
        while (rdy_cnt == start && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (rdy_cnt == start) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int prev_rdy;
        int base_cnt;
        clrn = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        ctrl_SIGNED = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_result", {32'd0, data_result}, 64'd0);
        chk("rst_result_hi", {32'd0, data_result_hi}, 64'd0);
        chk("rst_exc", {63'd0, data_exception}, 64'd0);
        chk("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        clrn = 1'b1;
        @(negedge clock);

        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        wait_rdy("umul");
        @(negedge clock);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("rdy_single_pulse", {63'd0, data_resultRDY}, 64'd0);
        chk("result_held", {32'd0, data_result}, 64'h0000_0000_FFFF_FFFE);

        // Back-to-back: next request issued during DONE.
        issue(1'b1, 1'b0, -32'sd7, 32'd6, 1'b1, 1'b1);
        wait_rdy("smul");
        prev_rdy = last_rdy_cyc;
        issue(1'b0, 1'b1, -32'sd7, 32'd2, 1'b1, 1'b1);
        wait_rdy("sdiv");
        chk("rdy_to_rdy", 64'(last_rdy_cyc - prev_rdy), 64'(W + 2));

        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_rdy("min_neg1");
        issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, 1'b1);
        wait_rdy("div0");
        issue(1'b0, 1'b1, -32'sd5, 32'd0, 1'b1, 1'b1);
        wait_rdy("sdiv0");

        // A divide request in the middle of a multiply must be ignored.
        issue(1'b1, 1'b0, 32'd12345, 32'd678, 1'b0, 1'b1);
        repeat (4) @(negedge clock);
        data_operandA = 32'd99;
        data_operandB = 32'd3;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy("ignore_div");

        // Both requests together: multiply wins.
        @(negedge clock);
        issue(1'b1, 1'b1, 32'd3, 32'd5, 1'b0, 1'b1);
        wait_rdy("both");

        // Asynchronous reset around iteration 10 of a multiply.
        @(negedge clock);
        base_cnt = rdy_cnt;
        issue(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        repeat (9) @(negedge clock);
        #2 clrn = 1'b0;
        #1;
        chk("midrst_result", {32'd0, data_result}, 64'd0);
        chk("midrst_result_hi", {32'd0, data_result_hi}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_rdy", {63'd0, data_resultRDY}, 64'd0);
        @(negedge clock);
        clrn = 1'b1;
        repeat (40) @(negedge clock);
        chk("midrst_no_rdy", 64'(rdy_cnt - base_cnt), 64'd0);
        clrn = 1'b0;
        @(negedge clock);
        clrn = 1'b1;
        issue(1'b1, 1'b0, 32'd7, 32'd9, 1'b1, 1'b1);
        wait_rdy("after_release");

        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 1) == 1, 1'b1, rnd_val(), rnd_val(),
                  $urandom_range(0, 1) == 1, 1'b1);
            wait_rdy("random");
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
